voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer.sv | 160 ++++++++++++++++
 tb/tb_voice_mixer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// Multi-voice mixer: per-voice gain/mute accumulation, master volume, saturation to DAC code.
// Optional sticky clip indicator enabled by defining MIXER_CLIP_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for sample_tick, inputs snapshotted on accept
// ACCUM | one voice per cycle added into the signed accumulator
// SCALE | phase 0: multiply by master volume; phase 1: shift, saturate, publish
module voice_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_VOICES*VOICE_W-1:0]  voice_in,
  input  logic [NUM_VOICES*4-1:0]        gain,
  input  logic [NUM_VOICES-1:0]          mute,
  input  logic [3:0]                     master_vol,
  input  logic                           sample_tick,
`ifdef MIXER_CLIP_FLAG_EN
  input  logic                           clip_clr,
  output logic                           clip_flag,
`endif
  output logic [VOICE_W-1:0]             mix_out,
  output logic                           mix_valid,
  output logic                           busy
);

  localparam int TW = VOICE_W + 5;
  localparam int AW = VOICE_W + 5 + $clog2(NUM_VOICES);
  localparam int PW = AW + 5;
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [VOICE_W-1:0] MID = {1'b1, {(VOICE_W-1){1'b0}}};
  localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (VOICE_W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = -SAT_HI - PW'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                          state;
  logic [IW-1:0]                   idx;
  logic signed [AW-1:0]            acc;
  logic signed [PW-1:0]            prod;
  logic                            phase;
  logic                            ready;
  logic [NUM_VOICES*VOICE_W-1:0]   voice_r;
  logic [NUM_VOICES*4-1:0]         gain_r;
  logic [NUM_VOICES-1:0]           mute_r;
  logic [3:0]                      mvol_r;

  logic [VOICE_W-1:0]              v_sel;
  logic [3:0]                      g_sel;
  logic                            m_sel;
  logic [3:0]                      g_eff;
  logic signed [VOICE_W-1:0]       diff;
  logic signed [TW-1:0]            term;
  logic signed [AW-1:0]            acc_next;
  logic signed [PW-1:0]            scaled;
  logic signed [PW-1:0]            sat_full;
  logic                            clipped;

  always_comb begin
    v_sel = '0;
    g_sel = '0;
    m_sel = 1'b0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (idx == IW'(k)) begin
        v_sel = voice_r[k*VOICE_W +: VOICE_W];
        g_sel = gain_r[k*4 +: 4];
        m_sel = mute_r[k];
      end
    end
    // Offset-binary to two's complement is just an MSB flip.
    diff     = $signed({~v_sel[VOICE_W-1], v_sel[VOICE_W-2:0]});
    g_eff    = m_sel ? 4'd0 : g_sel;
    term     = TW'(diff) * TW'({1'b0, g_eff});
    acc_next = acc + AW'(term);
    scaled   = prod >>> 8;
    clipped  = 1'b0;
    sat_full = scaled;
    if (scaled > SAT_HI) begin
      sat_full = SAT_HI;
      clipped  = 1'b1;
    end else if (scaled < SAT_LO) begin
      sat_full = SAT_LO;
      clipped  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      prod      <= '0;
      phase     <= 1'b0;
      ready     <= 1'b0;
      voice_r   <= '0;
      gain_r    <= '0;
      mute_r    <= '0;
      mvol_r    <= '0;
      mix_out   <= MID;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready     <= 1'b1;
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          // ready blocks a tick in the first cycle after reset release
          if (sample_tick && ready) begin
            voice_r <= voice_in;
            gain_r  <= gain;
            mute_r  <= mute;
            mvol_r  <= master_vol;
            acc     <= '0;
            idx     <= '0;
            phase   <= 1'b0;
            busy    <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= SCALE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        SCALE: begin
          if (!phase) begin
            prod  <= PW'(acc) * PW'(mvol_r);
            phase <= 1'b1;
          end else begin
            mix_out   <= {~sat_full[VOICE_W-1], sat_full[VOICE_W-2:0]};
            mix_valid <= 1'b1;
            busy      <= 1'b0;
            phase     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIXER_CLIP_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clip_flag <= 1'b0;
    end else if (state == SCALE && phase && clipped) begin
      clip_flag <= 1'b1;
    end else if (clip_clr) begin
      clip_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (3 voices, 12-bit): vector table plus reset/overlap sequences.
module tb_voice_mixer;

  logic        clk;
  logic        rst_n;
  logic [35:0] voice_in;
  logic [11:0] gain;
  logic [2:0]  mute;
  logic [3:0]  master_vol;
  logic        sample_tick;
  logic [11:0] mix_out;
  logic        mix_valid;
  logic        busy;
`ifdef MIXER_CLIP_FLAG_EN
  logic        clip_clr;
  logic        clip_flag;
`endif

  int tests = 0;
  int fails = 0;

  voice_mixer #(.NUM_VOICES(3), .VOICE_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .voice_in    (voice_in),
    .gain        (gain),
    .mute        (mute),
    .master_vol  (master_vol),
    .sample_tick (sample_tick),
`ifdef MIXER_CLIP_FLAG_EN
    .clip_clr    (clip_clr),
    .clip_flag   (clip_flag),
`endif
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v0, v1, v2;
    logic [3:0]  g0, g1, g2;
    logic [2:0]  mute;
    logic [3:0]  mvol;
    logic [11:0] exp_out;
    logic        exp_clip;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v);
    voice_in   = {v.v2, v.v1, v.v0};
    gain       = {v.g2, v.g1, v.g0};
    mute       = v.mute;
    master_vol = v.mvol;
  endtask

  task automatic run_mix(input logic [11:0] exp_out, input string tag);
    int lat;
    lat = 0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check({tag, " busy_after_tick"}, 32'(busy), 32'd1);
    while (!mix_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " mix_out"}, 32'(mix_out), 32'(exp_out));
    check({tag, " busy_at_valid"}, 32'(busy), 32'd0);
    step();
    check({tag, " valid_one_cycle"}, 32'(mix_valid), 32'd0);
    check({tag, " mix_out_held"}, 32'(mix_out), 32'(exp_out));
  endtask

  initial begin
    int   nvalid;
    int   vcyc;
    logic [11:0] got;

    //         v0      v1      v2      g0    g1    g2    mute    mvol  exp      clip
    vecs[0] = '{12'h800, 12'h800, 12'h800, 4'hF, 4'hF, 4'hF, 3'b000, 4'hF, 12'h800, 1'b0};
    vecs[1] = '{12'hFFF, 12'h800, 12'h800, 4'hF, 4'hF, 4'hF, 3'b110, 4'hF, 12'hF07, 1'b0};
    vecs[2] = '{12'h000, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 4'hF, 3'b110, 4'hF, 12'h0F8, 1'b0};
    vecs[3] = '{12'h000, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 4'hF, 3'b110, 4'h0, 12'h800, 1'b0};
    vecs[4] = '{12'hFFF, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 4'hF, 3'b000, 4'hF, 12'hFFF, 1'b1};
    vecs[5] = '{12'h000, 12'h000, 12'h000, 4'hF, 4'hF, 4'hF, 3'b000, 4'hF, 12'h000, 1'b1};
    vecs[6] = '{12'h900, 12'h700, 12'hC00, 4'h8, 4'h4, 4'h2, 3'b000, 4'hA, 12'h878, 1'b0};
    vecs[7] = '{12'h801, 12'h800, 12'h800, 4'h1, 4'h0, 4'h0, 3'b000, 4'hF, 12'h800, 1'b0};
    vecs[8] = '{12'h7FF, 12'hFFF, 12'h000, 4'h1, 4'hF, 4'hF, 3'b110, 4'hF, 12'h7FF, 1'b0};
    vecs[9] = '{12'hFFF, 12'h810, 12'h800, 4'h0, 4'h3, 4'h9, 3'b000, 4'hF, 12'h802, 1'b0};

    rst_n       = 1'b0;
    sample_tick = 1'b0;
    voice_in    = '0;
    gain        = '0;
    mute        = '0;
    master_vol  = '0;
`ifdef MIXER_CLIP_FLAG_EN
    clip_clr    = 1'b0;
`endif
    repeat (2) step();
    check("reset mix_out", 32'(mix_out), 32'h800);
    check("reset mix_valid", 32'(mix_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
`ifdef MIXER_CLIP_FLAG_EN
    check("reset clip_flag", 32'(clip_flag), 32'd0);
`endif

    // A tick in the release cycle must be ignored.
    load(vecs[1]);
    rst_n       = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("release tick ignored", 32'(busy), 32'd0);
    step();
    check("release still idle", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
`ifdef MIXER_CLIP_FLAG_EN
      clip_clr = 1'b1;
      step();
      clip_clr = 1'b0;
      check($sformatf("vec%0d clip_cleared", i), 32'(clip_flag), 32'd0);
`endif
      load(vecs[i]);
      run_mix(vecs[i].exp_out, $sformatf("vec%0d", i));
`ifdef MIXER_CLIP_FLAG_EN
      check($sformatf("vec%0d clip_flag", i), 32'(clip_flag), 32'(vecs[i].exp_clip));
`endif
    end

    // Second tick while busy, plus inputs changed mid-mix.
    load(vecs[6]);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    nvalid = 0;
    vcyc   = 0;
    got    = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        sample_tick = 1'b1;
        load(vecs[4]);
      end else begin
        sample_tick = 1'b0;
      end
      if (c == 3) load(vecs[5]);
      step();
      if (mix_valid) begin
        nvalid++;
        got  = mix_out;
        vcyc = c;
      end
    end
    sample_tick = 1'b0;
    check("overlap valid count", 32'(nvalid), 32'd1);
    check("overlap latency", 32'(vcyc), 32'd5);
    check("overlap mix_out", 32'(got), 32'h878);

    // Reset during ACCUM aborts the mix.
    load(vecs[1]);
    run_mix(12'hF07, "pre_abort");
    load(vecs[5]);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort mix_out", 32'(mix_out), 32'h800);
    check("abort busy", 32'(busy), 32'd0);
    check("abort mix_valid", 32'(mix_valid), 32'd0);
    rst_n  = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mix_valid) nvalid++;
    end
    check("abort no valid", 32'(nvalid), 32'd0);
    load(vecs[2]);
    run_mix(12'h0F8, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
